// File: rtl/gift_inv_affine_serial.sv
// Serial 3-share inverse GIFT affine engine: one nibble per clock, shares never recombined.
// Optional per-nibble remasking from the rnd port when GIFT_INV_AFFINE_REMASK_EN is defined.
module gift_inv_affine_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [63:0] x1,
  input  logic [63:0] x2,
  input  logic [63:0] x3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] y1,
  output logic [63:0] y2,
  output logic [63:0] y3,
  output logic        busy
`ifdef GIFT_INV_AFFINE_REMASK_EN
  ,
  input  logic [7:0]  rnd
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        mode_reg;
  logic        load_en;
  logic        shift_en;
  logic [63:0] share_reg [3];
  logic [63:0] share_in  [3];
  logic [3:0]  nib_map   [3];
  logic [3:0]  mask      [3];

  // c selects the affine constant; only share 1 carries it.
  function automatic logic [3:0] inv_affine1(input logic [3:0] b, input logic c);
    return {b[3] ^ b[2] ^ b[1] ^ b[0], c ^ b[3] ^ b[0], b[0], b[3] ^ b[1] ^ b[0]};
  endfunction

  function automatic logic [3:0] inv_affine2(input logic [3:0] b, input logic c);
    return {c ^ b[0], b[2], c ^ b[1] ^ b[0], b[3] ^ b[0]};
  endfunction

  assign share_in[0] = x1;
  assign share_in[1] = x2;
  assign share_in[2] = x3;

`ifdef GIFT_INV_AFFINE_REMASK_EN
  // Masks XOR to zero across shares, so the unmasked value is untouched.
  assign mask[0] = rnd[3:0] ^ rnd[7:4];
  assign mask[1] = rnd[3:0];
  assign mask[2] = rnd[7:4];
`else
  assign mask[0] = 4'h0;
  assign mask[1] = 4'h0;
  assign mask[2] = 4'h0;
`endif

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_share
      localparam logic AFF_CONST = (gi == 0);

      assign nib_map[gi] = (mode_reg ? inv_affine1(share_reg[gi][3:0], AFF_CONST)
                                     : inv_affine2(share_reg[gi][3:0], AFF_CONST)) ^ mask[gi];

      // Rotate right by one nibble so nibble i is back in place after 16 steps.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          share_reg[gi] <= 64'h0;
        end else if (load_en) begin
          share_reg[gi] <= share_in[gi];
        end else if (shift_en) begin
          share_reg[gi] <= {nib_map[gi], share_reg[gi][63:4]};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      mode_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_en) begin
        cnt_reg  <= 4'd0;
        mode_reg <= mode;
      end else if (shift_en) begin
        cnt_reg  <= cnt_reg + 4'd1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_en    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_reg == 4'd15) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign y1 = share_reg[0];
  assign y2 = share_reg[1];
  assign y3 = share_reg[2];

endmodule

// File: tb/tb_gift_inv_affine_serial.sv
// Scoreboard bench for gift_inv_affine_serial: latency, handshakes, reset and share-wise correctness.
module tb_gift_inv_affine_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [63:0] x1 = '0, x2 = '0, x3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] y1, y2, y3;
  logic        busy;
`ifdef GIFT_INV_AFFINE_REMASK_EN
  logic [7:0]  rnd = 8'h0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  time last_accept = 0;

  typedef struct {
    logic [63:0] e1, e2, e3, ex;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

`ifdef GIFT_INV_AFFINE_REMASK_EN
  always @(negedge clk) rnd = 8'($urandom);
`endif

  gift_inv_affine_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready),
    .y1(y1), .y2(y2), .y3(y3), .busy(busy)
`ifdef GIFT_INV_AFFINE_REMASK_EN
    , .rnd(rnd)
`endif
  );

  // Reference: per-nibble inverse affine maps written directly from the bit equations.
  function automatic logic [63:0] model(input logic [63:0] x, input logic m, input logic first);
    logic [63:0] r;
    logic [3:0]  b, a;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = x[4*i +: 4];
      if (m) begin
        a[3] = b[3] ^ b[2] ^ b[1] ^ b[0];
        a[2] = first ? ~(b[3] ^ b[0]) : (b[3] ^ b[0]);
        a[1] = b[0];
        a[0] = b[3] ^ b[1] ^ b[0];
      end else begin
        a[3] = first ? ~b[0] : b[0];
        a[2] = b[2];
        a[1] = first ? ~(b[1] ^ b[0]) : (b[1] ^ b[0]);
        a[0] = b[3] ^ b[0];
      end
      r[4*i +: 4] = a;
    end
    return r;
  endfunction

  task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic m);
    exp_t e;
    bit   accepted;
    int   lat;
    e.e1 = model(a, m, 1'b1);
    e.e2 = model(b, m, 1'b0);
    e.e3 = model(c, m, 1'b0);
    e.ex = model(a ^ b ^ c, m, 1'b1);
    @(negedge clk);
    x1 = a; x2 = b; x3 = c; mode = m; in_valid = 1'b1;
    accepted = 0;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin accepted = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!accepted) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    last_accept = $time;
    #1;
    in_valid = 1'b0; x1 = ~a; x2 = ~b; x3 = ~c; mode = ~m;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL run_flags: busy=%b in_ready=%b required 1/0", busy, in_ready);
        end
      end
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    n_checks++;
    if (lat != 16) begin
      n_fail++;
      $display("FAIL latency: got %0d edges required 16", lat);
    end
    e = sb.pop_front();
    n_checks++;
    if ((y1 ^ y2 ^ y3) !== e.ex) begin
      n_fail++;
      $display("FAIL unmasked: got %h required %h", y1 ^ y2 ^ y3, e.ex);
    end
`ifndef GIFT_INV_AFFINE_REMASK_EN
    n_checks++;
    if (y1 !== e.e1 || y2 !== e.e2 || y3 !== e.e3) begin
      n_fail++;
      $display("FAIL shares: got %h %h %h required %h %h %h", y1, y2, y3, e.e1, e.e2, e.e3);
    end
`endif
    $display("txn mode=%0d x=%h y1^y2^y3=%h lat=%0d", m, a ^ b ^ c, y1 ^ y2 ^ y3, lat);
    if (out_ready) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        y1 !== 64'h0 || y2 !== 64'h0 || y3 !== 64'h0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b y1=%h y2=%h y3=%h required 1/0/0/0/0/0",
               tag, in_ready, out_valid, busy, y1, y2, y3);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk); rst = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_known_vectors();
    logic [63:0] lit;
    out_ready = 1'b0;
    do_txn(64'h0, 64'h0, 64'h0, 1'b1);
`ifndef GIFT_INV_AFFINE_REMASK_EN
    lit = 64'h4444444444444444;
    n_checks++;
    if (y1 !== lit || y2 !== 64'h0 || y3 !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_aff1: y1=%h y2=%h y3=%h required %h 0 0", y1, y2, y3, lit);
    end
`endif
    release_out();
    do_txn(64'h6666666666666666, 64'h0, 64'h0, 1'b1);
    lit = 64'h5555555555555555;
    n_checks++;
    if ((y1 ^ y2 ^ y3) !== lit) begin
      n_fail++;
      $display("FAIL six_aff1: got %h required %h", y1 ^ y2 ^ y3, lit);
    end
    release_out();
    do_txn(64'h9999999999999999, 64'h0, 64'h0, 1'b0);
    n_checks++;
    if ((y1 ^ y2 ^ y3) !== 64'h0) begin
      n_fail++;
      $display("FAIL nine_aff2: got %h required 0", y1 ^ y2 ^ y3);
    end
    release_out();
  endtask

  task automatic test_random();
    logic [63:0] s, r2, r3;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s  = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      r3 = {$urandom, $urandom};
      do_txn(s ^ r2 ^ r3, r2, r3, 1'(i % 2));
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    time t0;
    out_ready = 1'b1;
    do_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    t0 = last_accept;
    do_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    n_checks++;
    if (last_accept - t0 != 180) begin
      n_fail++;
      $display("FAIL throughput: accept spacing %0t required 180", last_accept - t0);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] h1, h2, h3;
    int bad;
    out_ready = 1'b0;
    do_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    h1 = y1; h2 = y2; h3 = y3;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (y1 !== h1 || y2 !== h2 || y3 !== h3 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: %0d unstable cycles required 0 (out_valid=%b in_ready=%b)",
               bad, out_valid, in_ready);
    end
    release_out();
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    x1 = {$urandom, $urandom}; x2 = {$urandom, $urandom}; x3 = {$urandom, $urandom};
    mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_reset_values("mid_run_reset");
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    do_txn({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
